// File: rtl/spc_link_decoder.sv
// spc_link_decoder
// Passive decoder for the single-wire, open-drain, pulled-up link between the two
// AVR units. The raw wire is synchronised and glitch-filtered, then the widths of
// low and high pulses are measured in clk cycles. A long low pulse (break) opens a
// frame. Every following low pulse carries one data bit, MSB first: short lows
// decode as 1 and long lows decode as 0. Each completed byte is reported with a
// one-cycle strobe. An aborted partial byte is reported with a one-cycle error
// strobe.
//
// Pipeline from a raw line_in edge to a registered strobe:
//   2 synchroniser flops + GLITCH filter samples + 1 edge-detect cycle
//   = GLITCH+3 clk cycles.
//
// state_dbg mirrors the FSM state encoding:
//   0 IDLE, 1 LOW_SYNC, 2 GAP, 3 BIT_LOW

module spc_link_decoder #(
   parameter int CNT_W      = 16,
   parameter int GLITCH     = 2,
   parameter int BIT_THRESH = 64,
   parameter int BREAK_MIN  = 512,
   parameter int TIMEOUT    = 2048
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             line_in,
   output logic [7:0]       byte_out,
   output logic             byte_valid,
   output logic             frame_err,
   output logic             busy,
   output logic [CNT_W-1:0] last_low,
   output logic [CNT_W-1:0] last_high,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOW_SYNC = 2'd1,
      GAP      = 2'd2,
      BIT_LOW  = 2'd3
   } state_t;

   localparam int              FW        = (GLITCH > 1) ? $clog2(GLITCH) : 1;
   localparam logic [FW-1:0]   FLT_LAST  = FW'(GLITCH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] BRK_W    = CNT_W'(BREAK_MIN);
   localparam logic [CNT_W-1:0] THR_W    = CNT_W'(BIT_THRESH);
   localparam logic [CNT_W-1:0] TMO_W    = CNT_W'(TIMEOUT);

   // Input path
   logic          sync1;
   logic          sync2;
   logic          line_f;
   logic          line_f_q;
   logic          line_f_nxt;
   logic          flt_flip;
   logic [FW-1:0] flt_cnt;
   logic          fall;
   logic          rise;

   // Width counters
   logic [CNT_W-1:0] lo_cnt;
   logic [CNT_W-1:0] hi_cnt;

   // Frame state
   state_t     state;
   logic [2:0] bitcnt;
   logic [7:0] shreg;
   logic       bit_val;
   logic [7:0] shift_nxt;

   assign state_dbg = state;

   // Two-flop synchroniser. Anything other than a solid 0 (including z and x
   // from the open-drain wire) is read as the pulled-up idle level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= (line_in === 1'b0) ? 1'b0 : 1'b1;
         sync2 <= sync1;
      end
   end

   // The filtered line flips once the synchronised line has disagreed with it
   // for GLITCH consecutive samples. Any agreeing sample restarts the run.
   assign flt_flip   = (sync2 != line_f) && (flt_cnt == FLT_LAST);
   assign line_f_nxt = flt_flip ? sync2 : line_f;

   // Glitch filter state and the one-cycle-delayed copy used for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_f   <= 1'b1;
         line_f_q <= 1'b1;
         flt_cnt  <= '0;
      end else begin
         line_f   <= line_f_nxt;
         line_f_q <= line_f;
         if ((sync2 == line_f) || flt_flip) begin
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   assign fall = line_f_q & ~line_f;
   assign rise = ~line_f_q & line_f;

   // Pulse-width counters. Each restarts at 1 on the edge that begins its level
   // and saturates instead of wrapping. It holds while the other level is
   // present, so at rise/fall it still holds the width of the pulse just ended.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_cnt <= '0;
         hi_cnt <= '0;
      end else if (!line_f_nxt) begin
         if (line_f) begin
            lo_cnt <= CNT_ONE;
         end else if (lo_cnt != CNT_MAX) begin
            lo_cnt <= lo_cnt + 1'b1;
         end
      end else begin
         if (!line_f) begin
            hi_cnt <= CNT_ONE;
         end else if (hi_cnt != CNT_MAX) begin
            hi_cnt <= hi_cnt + 1'b1;
         end
      end
   end

   assign bit_val   = (lo_cnt < THR_W);
   assign shift_nxt = {shreg[6:0], bit_val};

   // Frame FSM with registered strobes, busy flag and last-width reports
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bitcnt     <= '0;
         shreg      <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
         last_low   <= '0;
         last_high  <= '0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (rise) begin
            last_low <= lo_cnt;
         end
         if (fall) begin
            last_high <= hi_cnt;
         end

         case (state)
            IDLE: begin
               if (fall) begin
                  state <= LOW_SYNC;
                  busy  <= 1'b1;
               end
            end

            LOW_SYNC: begin
               // A short low outside a frame is noise: drop it silently
               if (rise) begin
                  if (lo_cnt >= BRK_W) begin
                     state  <= GAP;
                     bitcnt <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end

            GAP: begin
               // A fall takes priority over a timeout in the same cycle
               if (fall) begin
                  state <= BIT_LOW;
               end else if (hi_cnt >= TMO_W) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  frame_err <= (bitcnt != 3'd0);
                  bitcnt    <= '0;
               end
            end

            BIT_LOW: begin
               if (rise) begin
                  state <= GAP;
                  if (lo_cnt >= BRK_W) begin
                     // A break inside a frame restarts byte alignment
                     frame_err <= (bitcnt != 3'd0);
                     bitcnt    <= '0;
                  end else if (bitcnt == 3'd7) begin
                     byte_out   <= shift_nxt;
                     byte_valid <= 1'b1;
                     shreg      <= shift_nxt;
                     bitcnt     <= '0;
                  end else begin
                     shreg  <= shift_nxt;
                     bitcnt <= bitcnt + 3'd1;
                  end
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
